bcd_conv_arbiter: RTL and testbench
===================================

// Module: bcd_conv_arbiter
// PURPOSE
//  Round-robin arbiter plus sequencer sharing one iterative 6-bit binary-to-BCD
//  (double-dabble, add-3/shift) converter among N_REQ requesters.
//  Performs one add-3/shift step per clock, so a full conversion costs 6 steps
//  instead of a combinational 6-stage chain.
//  Sits between the score/timer counters and the 7-segment display drivers.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  ID_W   2  width of the requester index; 2**ID_W >= N_REQ
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  req        in   N_REQ      req[i]=1: requester i wants a conversion
//  data       in   6*N_REQ    data[6*i+5:6*i] = binary value of requester i (0..63)
//  ack        out  N_REQ      one-hot, 1-cycle pulse: request i accepted
//  busy       out  1          1 whenever state != IDLE
//  out_valid  out  1          1-cycle pulse: ones/tens/out_id hold a new result
//  out_id     out  ID_W       index of the requester that owns the result
//  ones       out  4          BCD units digit
//  tens       out  4          BCD tens digit (0..6)
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0. ack=0, busy=0, out_valid=0, out_id=0,
//    ones=0, tens=0, scratch regs=0. Reset mid-conversion aborts it:
//    no out_valid, no ack, and the result is discarded.
//  - All outputs are registered.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: if req!=0, pick the winner w = first set req[k] scanning
//    k = rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
//    At the edge: latch data of w into sreg[5:0], bcd=0, cnt=0, id=w, go SHIFT.
//    ack[w]=1 in the next cycle only. req=0: stay IDLE, no ack.
//  - SHIFT: each edge, first add 3 to each bcd nibble that is >=5, then
//    {bcd,sreg} <<= 1 (sreg MSB enters bcd LSB); cnt++.
//    The edge with cnt==5 performs the 6th step, writes ones=bcd[3:0] and
//    tens=bcd[7:4] (post-shift values) and out_id=id, sets out_valid, and
//    goes to DONE.
//  - DONE: out_valid=1 for this cycle only. At the edge: rr_ptr=(id+1) mod
//    N_REQ, go IDLE. req is ignored in SHIFT and DONE.
//  - Timing: req sampled at edge E0; ack high in cycle E0..E1; out_valid
//    high in cycle E6..E7. The next request can be accepted at edge E8,
//    giving one conversion per 8 cycles.
//  - ones/tens/out_id hold their value until the next out_valid.
//  - req[i] still high after its ack is a new request and is served by
//    rotation. req[i] dropped before it wins is never acked.
//  - The bcd register is 8 bits; no overflow is possible for inputs <=63.
//  - busy=1 from the cycle after E0 through the DONE cycle.
// TESTING
//  1. Reset, req=0001, data0=45 -> ack=0001 one cycle after the sample edge,
//     out_valid 6 cycles later, tens=4 ones=5 out_id=0, busy low after DONE.
//  2. Boundaries: data0=0 -> tens=0 ones=0; data0=63 -> tens=6 ones=3;
//     data0=9 -> tens=0 ones=9; data0=10 -> tens=1 ones=0.
//  3. req=1111 held, data=63,42,17,5 (ids 0..3) -> four results in id order
//     0,1,2,3 with (6,3),(4,2),(1,7),(0,5), 8 cycles apart, then id 0 again.
//  4. Only req[3] served, then req=1001 -> id 0 wins (rr_ptr wrapped to 0),
//     then id 3.
//  5. rst pulsed during the 3rd SHIFT cycle -> no out_valid, all outputs 0,
//     rr_ptr=0; a fresh req converts correctly afterwards.
//  6. req[2] pulsed for 1 cycle while busy, then dropped -> never acked;
//     the output stream is unchanged.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
// Round-robin arbiter and sequencer that shares one iterative 6-bit
// binary-to-BCD converter (double dabble) among N_REQ requesters.
// The converter does one add-3/shift step per clock, so a conversion takes
// six SHIFT cycles plus one DONE cycle. After that the arbiter can accept
// the next request, which gives one result every 8 cycles under full load.
// All outputs are driven straight from flops.

module bcd_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [6*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 out_valid,
  output logic [ID_W-1:0]      out_id,
  output logic [3:0]           ones,
  output logic [3:0]           tens
);

  localparam int CW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [5:0]        sreg_q, sreg_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [3:0]        ones_q, ones_d;
  logic [3:0]        tens_q, tens_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [CW-1:0]     cand;
  logic [5:0]        data_sel;
  logic [N_REQ-1:0]  win_onehot;
  logic [7:0]        bcd_adj;
  logic [13:0]       shifted;

  // Scan the requests starting at rr_ptr and wrapping modulo N_REQ; the first set bit wins
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Select the winner's binary value and build its one-hot acknowledge
  always_comb begin
    data_sel   = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        data_sel      = data[6*i +: 6];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift the binary MSB into the BCD LSB
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) begin
      bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    end
    if (bcd_q[7:4] >= 4'd5) begin
      bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end
    shifted = {bcd_adj[6:0], sreg_q, 1'b0};
  end

  // Sequencer: next state, scratch registers and registered outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sreg_d      = sreg_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    ack_d       = '0;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    ones_d      = ones_q;
    tens_d      = tens_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          sreg_d  = data_sel;
          bcd_d   = '0;
          cnt_d   = '0;
          id_d    = win_id;
          ack_d   = win_onehot;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d  = shifted[13:6];
        sreg_d = shifted[5:0];
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          ones_d      = shifted[9:6];
          tens_d      = shifted[13:10];
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (id_q == ID_W'(N_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = id_q + ID_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; a reset mid-conversion discards the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sreg_q      <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      ones_q      <= '0;
      tens_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sreg_q      <= sreg_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign ones      = ones_q;
  assign tens      = tens_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter
// Directed bench for the shared BCD converter arbiter. A cycle-level model
// tracks acceptances, rotation and the 8-cycle conversion slot, and works out
// each result with decimal arithmetic. The DUT is compared with this model on
// every falling edge. Directed tests also pin results, latencies and acks to
// hand-computed constants.

module tb_bcd_conv_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [6*N-1:0] data;
  logic [N-1:0]  ack;
  logic          busy;
  logic          out_valid;
  logic [IW-1:0] out_id;
  logic [3:0]    ones;
  logic [3:0]    tens;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // model state and expected outputs
  int           m_phase = 0;
  int           m_rr    = 0;
  int           m_id    = 0;
  int           m_val   = 0;
  logic [N-1:0] exp_ack   = '0;
  logic         exp_busy  = 1'b0;
  logic         exp_valid = 1'b0;
  int           exp_id    = 0;
  int           exp_ones  = 0;
  int           exp_tens  = 0;

  bcd_conv_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .ones      (ones),
    .tens      (tens)
  );

  always #5 clk = ~clk;

  // Abort the run if anything hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
  endtask

  task automatic setData(input int id, input int val);
    data[6*id +: 6] = 6'(val);
  endtask

  // Wait on falling edges for the next result pulse and compare it with literals
  task automatic waitResult(input string name, input int eid, input int etens,
                            input int eones, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 20);
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no out_valid expected out_valid within 20 cycles", name);
    end else begin
      checkOutput({name, "_id"}, 32'(out_id), 32'(eid));
      checkOutput({name, "_tens"}, 32'(tens), 32'(etens));
      checkOutput({name, "_ones"}, 32'(ones), 32'(eones));
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 20);
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Single isolated conversion from the idle state
  task automatic convertOne(input string name, input int id, input int val,
                            input int etens, input int eones);
    int cyc;
    setData(id, val);
    applyStimulus(N'(1 << id));
    @(negedge clk);
    checkOutput({name, "_ack"}, 32'(ack), 32'(1 << id));
    applyStimulus('0);
    waitResult(name, id, etens, eones, cyc);
    checkOutput({name, "_lat"}, 32'(cyc), 32'd6);
    @(negedge clk);
    checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // Model: one acceptance per free slot, chosen by rotation from the last winner + 1
  always @(posedge clk) begin
    if (rst) begin
      m_phase   = 0;
      m_rr      = 0;
      exp_ack   = '0;
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      exp_id    = 0;
      exp_ones  = 0;
      exp_tens  = 0;
    end else begin
      exp_ack   = '0;
      exp_valid = 1'b0;
      if (m_phase == 0) begin
        if (req != '0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (req[(m_rr + k) % N]) m_id = (m_rr + k) % N;
          end
          m_val          = int'(data[6*m_id +: 6]);
          exp_ack[m_id]  = 1'b1;
          m_phase        = 1;
        end
      end else if (m_phase == 6) begin
        exp_valid = 1'b1;
        exp_id    = m_id;
        exp_tens  = m_val / 10;
        exp_ones  = m_val % 10;
        m_phase   = 7;
      end else if (m_phase == 7) begin
        m_phase = 0;
        m_rr    = (m_id + 1) % N;
      end else begin
        m_phase++;
      end
      exp_busy = (m_phase != 0);
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_ack", 32'(ack), 32'(exp_ack));
      checkOutput("cmp_busy", 32'(busy), 32'(exp_busy));
      checkOutput("cmp_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("cmp_id", 32'(out_id), 32'(exp_id));
      checkOutput("cmp_tens", 32'(tens), 32'(exp_tens));
      checkOutput("cmp_ones", 32'(ones), 32'(exp_ones));
    end
  end

  initial begin
    int cyc;
    int cnt_valid;
    int cnt_ack2;
    int vals [4];
    int rid  [5];

    vals = '{63, 42, 17, 5};
    rid  = '{0, 1, 2, 3, 0};
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_id", 32'(out_id), 32'd0);
    checkOutput("rst_ones", 32'(ones), 32'd0);
    checkOutput("rst_tens", 32'(tens), 32'd0);
    rst = 1'b0;

    $display("[TB] basic conversion 45");
    convertOne("t1_45", 0, 45, 4, 5);

    $display("[TB] boundary values");
    convertOne("t2_0", 0, 0, 0, 0);
    convertOne("t2_63", 0, 63, 6, 3);
    convertOne("t2_9", 0, 9, 0, 9);
    convertOne("t2_10", 0, 10, 1, 0);

    $display("[TB] all requesters held");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) setData(i, vals[i]);
    applyStimulus(4'b1111);
    for (int r = 0; r < 5; r++) begin
      waitResult($sformatf("t3_r%0d", r), rid[r], vals[rid[r]] / 10, vals[rid[r]] % 10, cyc);
      checkOutput($sformatf("t3_gap%0d", r), 32'(cyc), (r == 0) ? 32'd7 : 32'd8);
    end
    applyStimulus('0);
    waitIdle("t3");

    $display("[TB] pointer wrap after id 3");
    convertOne("t4_id3", 3, 27, 2, 7);
    setData(0, 50);
    applyStimulus(4'b1001);
    waitResult("t4_first", 0, 5, 0, cyc);
    checkOutput("t4_first_lat", 32'(cyc), 32'd7);
    waitResult("t4_second", 3, 2, 7, cyc);
    checkOutput("t4_second_gap", 32'(cyc), 32'd8);
    applyStimulus('0);
    waitIdle("t4");

    $display("[TB] reset during conversion");
    setData(2, 38);
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("t5_ack", 32'(ack), 32'b0100);
    applyStimulus('0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_id", 32'(out_id), 32'd0);
    checkOutput("t5_tens", 32'(tens), 32'd0);
    checkOutput("t5_ones", 32'(ones), 32'd0);
    cnt_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt_valid++;
    end
    checkOutput("t5_no_valid", 32'(cnt_valid), 32'd0);
    setData(0, 12);
    setData(3, 55);
    applyStimulus(4'b1001);
    waitResult("t5_after", 0, 1, 2, cyc);
    checkOutput("t5_after_lat", 32'(cyc), 32'd7);
    applyStimulus('0);
    waitIdle("t5");

    $display("[TB] request pulsed while busy");
    setData(0, 33);
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("t6_ack", 32'(ack), 32'b0001);
    applyStimulus('0);
    @(negedge clk);
    applyStimulus(4'b0100);
    @(negedge clk);
    applyStimulus('0);
    waitResult("t6_res", 0, 3, 3, cyc);
    checkOutput("t6_lat", 32'(cyc), 32'd4);
    cnt_ack2  = 0;
    cnt_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack[2] === 1'b1) cnt_ack2++;
      if (out_valid === 1'b1) cnt_valid++;
    end
    checkOutput("t6_no_ack2", 32'(cnt_ack2), 32'd0);
    checkOutput("t6_no_valid", 32'(cnt_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
